// File: rtl/x_multdiv_if.sv
// Bundle between the decode/execute pipeline and the x_multdiv multiply/divide unit.
// state is a debug view of the unit's FSM (IDLE=0, MULT=1, DIV=2, DONE=3).
interface x_multdiv_if #(
  parameter int DATA_WIDTH = 32
);
  // Handshake: a start strobe is taken only when busy is low; ready pulses for
  // exactly one cycle, and result/exception are meaningful in that cycle.
  logic                  start_mult;
  logic                  start_div;
  logic [DATA_WIDTH-1:0] operand_a;
  logic [DATA_WIDTH-1:0] operand_b;
  logic [DATA_WIDTH-1:0] result;
  logic                  exception;
  logic                  ready;
  logic                  busy;
  logic [1:0]            state;

  modport master (
    output start_mult, start_div, operand_a, operand_b,
    input  result, exception, ready, busy, state
  );

  modport slave (
    input  start_mult, start_div, operand_a, operand_b,
    output result, exception, ready, busy, state
  );
endinterface

// File: rtl/x_multdiv.sv
// Multi-cycle signed multiply (shift-add) / divide (restoring) unit with stall output.
// Optional macro MULTDIV_EARLY_TERM_EN ends MULT once the remaining multiplier bits are zero.
module x_multdiv #(
  parameter int DATA_WIDTH = 32
) (
  input  logic        clock,
  input  logic        reset,
  x_multdiv_if.slave  bus
);
  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state, state_next;

  logic [CW-1:0]  count;
  logic [2*W-1:0] acc;
  logic [2*W-1:0] addend;
  logic [W-1:0]   mplier;
  logic [W-1:0]   rem;
  logic [W-1:0]   quo;
  logic [W-1:0]   divisor;
  logic           sign;
  logic           div_zero;
  logic [W-1:0]   result;
  logic           exception;
  logic           ready;
  logic           busy;

  logic [W-1:0]   abs_a;
  logic [W-1:0]   abs_b;
  logic           accept;
  logic           last_iter;
  logic           mult_done;
  logic           div_done;
  logic [2*W-1:0] acc_step;
  logic [2*W-1:0] prod_signed;
  logic           mult_exc;
  logic [W:0]     shifted;
  logic [W-1:0]   diff;
  logic           fits;
  logic [W-1:0]   rem_step;
  logic [W-1:0]   quo_step;
  logic [W-1:0]   quo_signed;
  logic           div_exc;

  assign abs_a = bus.operand_a[W-1] ? -bus.operand_a : bus.operand_a;
  assign abs_b = bus.operand_b[W-1] ? -bus.operand_b : bus.operand_b;

  assign accept    = (state == IDLE || state == DONE) && (bus.start_mult || bus.start_div);
  assign last_iter = (count == CW'(W - 1));

`ifdef MULTDIV_EARLY_TERM_EN
  assign mult_done = last_iter || (mplier == '0);
`else
  assign mult_done = last_iter;
`endif
  assign div_done  = last_iter || div_zero;

  // Multiply: add the shifted multiplicand for each set multiplier bit.
  assign acc_step    = mplier[0] ? (acc + addend) : acc;
  assign prod_signed = sign ? -acc_step : acc_step;
  assign mult_exc    = (prod_signed[2*W-1:W] != {W{prod_signed[W-1]}});

  // Divide: the partial remainder is always < divisor, so the low W bits of
  // the difference are exact whenever the trial subtraction fits.
  assign shifted    = {rem, quo[W-1]};
  assign fits       = (shifted >= {1'b0, divisor});
  assign diff       = shifted[W-1:0] - divisor;
  assign rem_step   = fits ? diff : shifted[W-1:0];
  assign quo_step   = {quo[W-2:0], fits};
  assign quo_signed = sign ? -quo_step : quo_step;
  // A positive quotient with the top bit set only arises from MIN / -1.
  assign div_exc    = ~sign & quo_step[W-1];

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (bus.start_mult)     state_next = MULT;
        else if (bus.start_div) state_next = DIV;
      end
      MULT: if (mult_done) state_next = DONE;
      DIV:  if (div_done)  state_next = DONE;
      DONE: begin
        if (bus.start_mult)     state_next = MULT;
        else if (bus.start_div) state_next = DIV;
        else                    state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      count     <= '0;
      acc       <= '0;
      addend    <= '0;
      mplier    <= '0;
      rem       <= '0;
      quo       <= '0;
      divisor   <= '0;
      sign      <= 1'b0;
      div_zero  <= 1'b0;
      result    <= '0;
      exception <= 1'b0;
      ready     <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state <= state_next;
      ready <= (state_next == DONE);
      busy  <= (state_next == MULT) || (state_next == DIV);
      if (accept) begin
        count     <= '0;
        acc       <= '0;
        addend    <= {{W{1'b0}}, abs_a};
        mplier    <= abs_b;
        rem       <= '0;
        quo       <= abs_a;
        divisor   <= abs_b;
        sign      <= bus.operand_a[W-1] ^ bus.operand_b[W-1];
        div_zero  <= ~bus.start_mult & (bus.operand_b == '0);
        result    <= '0;
        exception <= 1'b0;
      end else if (state == MULT) begin
        acc    <= acc_step;
        addend <= addend << 1;
        mplier <= mplier >> 1;
        count  <= count + CW'(1);
        if (mult_done) begin
          result    <= prod_signed[W-1:0];
          exception <= mult_exc;
        end
      end else if (state == DIV) begin
        rem   <= rem_step;
        quo   <= quo_step;
        count <= count + CW'(1);
        if (div_done) begin
          result    <= div_zero ? '0 : quo_signed;
          exception <= div_zero | div_exc;
        end
      end
    end
  end

  assign bus.result    = result;
  assign bus.exception = exception;
  assign bus.ready     = ready;
  assign bus.busy      = busy;
  assign bus.state     = state;
endmodule

// File: tb/tb_x_multdiv.sv
// Directed bench for x_multdiv: vector table of signed mul/div cases plus
// hand sequences for ignored starts, back-to-back issue and mid-operation reset.
module tb_x_multdiv;
  logic clock;
  logic reset;
  int   tests;
  int   fails;

  x_multdiv_if #(.DATA_WIDTH(32)) bus ();

  x_multdiv #(.DATA_WIDTH(32)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        is_div;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        exc;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic int exp_mult_lat(input logic [31:0] b);
`ifdef MULTDIV_EARLY_TERM_EN
    logic [31:0] mag;
    int          n;
    mag = b[31] ? -b : b;
    n = 0;
    for (int i = 0; i < 32; i++) if (mag[i]) n = i + 1;
    return (n + 1 > 32) ? 32 : n + 1;
`else
    return 32 + 0 * int'(b[0]);
`endif
  endfunction

  function automatic int exp_lat(input logic is_div, input logic [31:0] b);
    if (is_div) return (b == 32'd0) ? 1 : 32;
    return exp_mult_lat(b);
  endfunction

  // Called between clock edges; returns #1 after the accept edge.
  task automatic launch(input logic is_div, input logic [31:0] a, input logic [31:0] b);
    bus.start_mult = ~is_div;
    bus.start_div  = is_div;
    bus.operand_a  = a;
    bus.operand_b  = b;
    @(posedge clock);
    #1;
    bus.start_mult = 1'b0;
    bus.start_div  = 1'b0;
  endtask

  // Returns #1 after the edge that raised ready (lat = edges after accept, -1 on timeout).
  task automatic wait_done(output int lat, output int busy_n);
    lat    = -1;
    busy_n = 0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clock);
      #1;
      if (bus.ready) begin
        lat = n;
        break;
      end
      if (bus.busy) busy_n++;
    end
  endtask

  vec_t vecs[18];
  int   lat;
  int   busy_n;
  int   elat;
  int   ready_seen;

  initial begin
    tests = 0;
    fails = 0;
    bus.start_mult = 1'b0;
    bus.start_div  = 1'b0;
    bus.operand_a  = '0;
    bus.operand_b  = '0;

    vecs[0]  = '{1'b0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0};
    vecs[1]  = '{1'b1, 32'hFFFFFF9C, 32'd7,        32'hFFFFFFF2, 1'b0};
    vecs[2]  = '{1'b1, 32'd100,      32'd7,        32'd14,       1'b0};
    vecs[3]  = '{1'b1, 32'd5,        32'd0,        32'd0,        1'b1};
    vecs[4]  = '{1'b0, 32'h00010000, 32'h00010000, 32'd0,        1'b1};
    vecs[5]  = '{1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1};
    vecs[6]  = '{1'b0, 32'd6,        32'd6,        32'd36,       1'b0};
    vecs[7]  = '{1'b0, 32'hFFFFFFF9, 32'hFFFFFFFD, 32'd21,       1'b0};
    vecs[8]  = '{1'b0, 32'h7FFFFFFF, 32'd2,        32'hFFFFFFFE, 1'b1};
    vecs[9]  = '{1'b0, 32'h80000000, 32'd1,        32'h80000000, 1'b0};
    vecs[10] = '{1'b0, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1};
    vecs[11] = '{1'b1, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 1'b0};
    vecs[12] = '{1'b1, 32'd7,        32'hFFFFFFF9, 32'hFFFFFFFF, 1'b0};
    vecs[13] = '{1'b1, 32'h80000000, 32'd1,        32'h80000000, 1'b0};
    vecs[14] = '{1'b0, 32'd0,        32'h00012345, 32'd0,        1'b0};
    vecs[15] = '{1'b1, 32'd3,        32'd10,       32'd0,        1'b0};
    vecs[16] = '{1'b0, 32'h00012345, 32'hFFFF0000, 32'hDCBB0000, 1'b1};
    vecs[17] = '{1'b1, 32'h7FFFFFFF, 32'h10,       32'h07FFFFFF, 1'b0};

    // Reset values
    reset = 1'b1;
    #12;
    check("rst_result", 64'(bus.result), 64'd0);
    check("rst_exception", 64'(bus.exception), 64'd0);
    check("rst_ready", 64'(bus.ready), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_state", 64'(bus.state), 64'd0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    for (int i = 0; i < 18; i++) begin
      elat = exp_lat(vecs[i].is_div, vecs[i].b);
      @(negedge clock);
      launch(vecs[i].is_div, vecs[i].a, vecs[i].b);
      check($sformatf("v%0d_busy_after_accept", i), 64'(bus.busy), 64'd1);
      wait_done(lat, busy_n);
      check($sformatf("v%0d_latency", i), 64'(lat), 64'(elat));
      check($sformatf("v%0d_result", i), 64'(bus.result), 64'(vecs[i].res));
      check($sformatf("v%0d_exception", i), 64'(bus.exception), 64'(vecs[i].exc));
      check($sformatf("v%0d_busy_at_done", i), 64'(bus.busy), 64'd0);
      check($sformatf("v%0d_busy_cycles", i), 64'(busy_n), 64'(elat - 1));
      @(posedge clock);
      #1;
      check($sformatf("v%0d_ready_pulse_end", i), 64'(bus.ready), 64'd0);
    end

    // Start strobe arriving at edge 10 of a running multiply is ignored
    @(negedge clock);
    launch(1'b0, 32'd7, 32'hFFFFFFFD);
    repeat (9) @(posedge clock);
    #1;
    bus.start_div = 1'b1;
    bus.operand_a = 32'd100;
    bus.operand_b = 32'd7;
    @(posedge clock);
    #1;
    bus.start_div = 1'b0;
    check("ign_state_still_mult", 64'(bus.state), 64'd1);
    wait_done(lat, busy_n);
    check("ign_latency", 64'(lat), 64'(exp_mult_lat(32'hFFFFFFFD) - 10));
    check("ign_result", 64'(bus.result), 64'hFFFFFFEB);
    check("ign_exception", 64'(bus.exception), 64'd0);

    // New start in the DONE cycle is accepted without an IDLE gap
    launch(1'b0, 32'd6, 32'd6);
    check("b2b_state_mult", 64'(bus.state), 64'd1);
    check("b2b_busy", 64'(bus.busy), 64'd1);
    wait_done(lat, busy_n);
    check("b2b_latency", 64'(lat), 64'(exp_mult_lat(32'd6)));
    check("b2b_result", 64'(bus.result), 64'd36);
    check("b2b_exception", 64'(bus.exception), 64'd0);

    // Same back-to-back issue into a divide
    launch(1'b1, 32'hFFFFFF9C, 32'd7);
    wait_done(lat, busy_n);
    check("b2b_div_latency", 64'(lat), 64'd32);
    check("b2b_div_result", 64'(bus.result), 64'hFFFFFFF2);

    // Both strobes high: multiply wins
    @(negedge clock);
    bus.start_mult = 1'b1;
    bus.start_div  = 1'b1;
    bus.operand_a  = 32'd100;
    bus.operand_b  = 32'd7;
    @(posedge clock);
    #1;
    bus.start_mult = 1'b0;
    bus.start_div  = 1'b0;
    check("both_state_mult", 64'(bus.state), 64'd1);
    wait_done(lat, busy_n);
    check("both_result", 64'(bus.result), 64'd700);

    // Reset between edges during iteration 15 aborts the operation
    @(negedge clock);
    launch(1'b0, 32'd7, 32'hFFFFFFFD);
    repeat (15) @(posedge clock);
    #3;
    check("pre_rst_busy", 64'(bus.busy), 64'd1);
    reset = 1'b1;
    #1;
    check("mid_rst_state", 64'(bus.state), 64'd0);
    check("mid_rst_busy", 64'(bus.busy), 64'd0);
    check("mid_rst_ready", 64'(bus.ready), 64'd0);
    check("mid_rst_result", 64'(bus.result), 64'd0);
    check("mid_rst_exception", 64'(bus.exception), 64'd0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    ready_seen = 0;
    for (int n = 0; n < 40; n++) begin
      @(posedge clock);
      #1;
      if (bus.ready) ready_seen++;
    end
    check("aborted_no_ready", 64'(ready_seen), 64'd0);
    @(negedge clock);
    launch(1'b0, 32'd6, 32'd6);
    wait_done(lat, busy_n);
    check("post_rst_latency", 64'(lat), 64'(exp_mult_lat(32'd6)));
    check("post_rst_result", 64'(bus.result), 64'd36);
    check("post_rst_exception", 64'(bus.exception), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
